// File: rtl/ocp_tree_router.sv
// ocp_tree_router: one-master / NSLV-slave OCP-lite router.
//   The top SELW address bits select a slave. Indices at or above NSLV are
//   holes and get an ERR response. Only one WR/RD transaction is in flight
//   at a time. A per-transaction timeout forces ERR. Writes are either
//   posted or wait for the slave response. ERR responses are counted in a
//   saturating counter.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   mst_MCmd/MAddr/MData          master request (000 IDLE, 001 WR, 010 RD)
//   mst_SCmdAccept                router can take a new command
//   mst_SResp/SData               one-cycle response to the master (00/01/11)
//   slv_MCmd                      per-slave command, slave k at [3k+2:3k]
//   slv_MAddr/MData               shared request address / write data
//   slv_SCmdAccept/SResp/SData    per-slave accept, response and read data
//   active_link                   debug {valid, index[2:0]}, 0 when idle
//   link_state                    debug 00 IDLE, 01 CMD, 10 RESP
//   err_count                     saturating ERR count
module ocp_tree_router #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int NSLV    = 2,
  parameter int SELW    = 1,
  parameter int TIMEOUT = 255,
  parameter int WR_RESP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           mst_MCmd,
  input  logic [AW-1:0]        mst_MAddr,
  input  logic [DW-1:0]        mst_MData,
  output logic                 mst_SCmdAccept,
  output logic [1:0]           mst_SResp,
  output logic [DW-1:0]        mst_SData,
  output logic [3*NSLV-1:0]    slv_MCmd,
  output logic [AW-1:0]        slv_MAddr,
  output logic [DW-1:0]        slv_MData,
  input  logic [NSLV-1:0]      slv_SCmdAccept,
  input  logic [2*NSLV-1:0]    slv_SResp,
  input  logic [DW*NSLV-1:0]   slv_SData,
  output logic [3:0]           active_link,
  output logic [1:0]           link_state,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [2:0] CMD_WR    = 3'b001;
  localparam logic [2:0] CMD_RD    = 3'b010;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  localparam int         TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit         TMO_EN   = (TIMEOUT > 0);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam int         IXW      = (SELW < 3) ? SELW : 3;
  localparam bit         POSTED   = (WR_RESP == 0);

  state_e              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic                hole_q, hole_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                mst_accept_q, mst_accept_d;
  logic [1:0]          mst_resp_q, mst_resp_d;
  logic [DW-1:0]       mst_sdata_q, mst_sdata_d;
  logic [3*NSLV-1:0]   slv_mcmd_q, slv_mcmd_d;
  logic [AW-1:0]       slv_maddr_q, slv_maddr_d;
  logic [DW-1:0]       slv_mdata_q, slv_mdata_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [SELW-1:0]     req_idx_s;
  logic                req_valid_s;
  logic                req_hole_s;
  logic                sel_accept_s;
  logic [1:0]          sel_resp_s;
  logic [DW-1:0]       sel_data_s;
  logic                timeout_hit_s;
  logic [TW-1:0]       tmo_inc_s;
  logic                err_inc_s;

  assign req_idx_s     = mst_MAddr[AW-1 -: SELW];
  assign req_valid_s   = (mst_MCmd == CMD_WR) || (mst_MCmd == CMD_RD);
  assign req_hole_s    = ({1'b0, req_idx_s} >= (SELW + 1)'(NSLV));
  // The count saturates at TMO_LAST, so the >= test stays true once reached.
  assign timeout_hit_s = TMO_EN && (tmo_cnt_q >= TMO_LAST);
  assign tmo_inc_s     = (tmo_cnt_q < TMO_LAST) ? tmo_cnt_q + TW'(1) : tmo_cnt_q;

  // Pick out accept/response/data of the latched slave; other slaves are ignored.
  always_comb begin
    sel_accept_s = 1'b0;
    sel_resp_s   = RESP_NULL;
    sel_data_s   = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q == SELW'(k)) begin
        sel_accept_s = slv_SCmdAccept[k];
        sel_resp_s   = slv_SResp[2*k +: 2];
        sel_data_s   = slv_SData[DW*k +: DW];
      end else begin
        sel_accept_s = sel_accept_s;
      end
    end
  end

  // Transaction FSM: next state, latched request and registered outputs.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    sel_d        = sel_q;
    hole_d       = hole_q;
    tmo_cnt_d    = tmo_cnt_q;
    mst_accept_d = mst_accept_q;
    mst_resp_d   = RESP_NULL;
    mst_sdata_d  = '0;
    slv_mcmd_d   = slv_mcmd_q;
    slv_maddr_d  = slv_maddr_q;
    slv_mdata_d  = slv_mdata_q;
    err_inc_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_s) begin
          cmd_d        = mst_MCmd;
          sel_d        = req_idx_s;
          slv_maddr_d  = mst_MAddr;
          slv_mdata_d  = mst_MData;
          tmo_cnt_d    = '0;
          mst_accept_d = 1'b0;
          if (req_hole_s) begin
            hole_d  = 1'b1;
            state_d = ST_RESP;
          end else begin
            hole_d  = 1'b0;
            state_d = ST_CMD;
            for (int k = 0; k < NSLV; k++) begin
              slv_mcmd_d[3*k +: 3] = (req_idx_s == SELW'(k)) ? mst_MCmd : 3'b000;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CMD: begin
        tmo_cnt_d = tmo_inc_s;
        if (sel_accept_s) begin
          slv_mcmd_d = '0;
          state_d    = ST_RESP;
        end else if (timeout_hit_s) begin
          slv_mcmd_d   = '0;
          mst_resp_d   = RESP_ERR;
          err_inc_s    = 1'b1;
          mst_accept_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_CMD;
        end
      end

      ST_RESP: begin
        tmo_cnt_d = tmo_inc_s;
        if (hole_q) begin
          mst_resp_d   = RESP_ERR;
          err_inc_s    = 1'b1;
          mst_accept_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (POSTED && (cmd_q == CMD_WR)) begin
          mst_resp_d   = RESP_DVA;
          mst_accept_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (sel_resp_s != RESP_NULL) begin
          // Anything other than DVA (including the reserved code) becomes ERR.
          if (sel_resp_s == RESP_DVA) begin
            mst_resp_d  = RESP_DVA;
            mst_sdata_d = sel_data_s;
          end else begin
            mst_resp_d = RESP_ERR;
            err_inc_s  = 1'b1;
          end
          mst_accept_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (timeout_hit_s) begin
          mst_resp_d   = RESP_ERR;
          err_inc_s    = 1'b1;
          mst_accept_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        mst_accept_d = 1'b1;
        slv_mcmd_d   = '0;
      end
    endcase
  end

  // Saturating ERR counter.
  always_comb begin
    if (err_inc_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 3'b000;
      sel_q        <= '0;
      hole_q       <= 1'b0;
      tmo_cnt_q    <= '0;
      mst_accept_q <= 1'b1;
      mst_resp_q   <= RESP_NULL;
      mst_sdata_q  <= '0;
      slv_mcmd_q   <= '0;
      slv_maddr_q  <= '0;
      slv_mdata_q  <= '0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      sel_q        <= sel_d;
      hole_q       <= hole_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mst_accept_q <= mst_accept_d;
      mst_resp_q   <= mst_resp_d;
      mst_sdata_q  <= mst_sdata_d;
      slv_mcmd_q   <= slv_mcmd_d;
      slv_maddr_q  <= slv_maddr_d;
      slv_mdata_q  <= slv_mdata_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign mst_SCmdAccept = mst_accept_q;
  assign mst_SResp      = mst_resp_q;
  assign mst_SData      = mst_sdata_q;
  assign slv_MCmd       = slv_mcmd_q;
  assign slv_MAddr      = slv_maddr_q;
  assign slv_MData      = slv_mdata_q;
  assign err_count      = err_cnt_q;
  assign link_state     = state_q;
  // A hole shows its index with the valid bit clear.
  assign active_link    = (state_q == ST_IDLE) ? 4'b0000
                                               : {~hole_q, 3'(sel_q[IXW-1:0])};

endmodule

// File: tb/tb_ocp_tree_router.sv
module tb_ocp_tree_router;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: default parameters (NSLV=2, SELW=1, TIMEOUT=255, posted writes)
  logic [2:0]  a_mcmd;
  logic [7:0]  a_maddr, a_mdata;
  logic        a_acc_o;
  logic [1:0]  a_resp_o;
  logic [7:0]  a_sdata_o;
  logic [5:0]  a_slv_mcmd;
  logic [7:0]  a_slv_maddr, a_slv_mdata;
  logic [1:0]  a_slv_acc;
  logic [3:0]  a_slv_resp;
  logic [15:0] a_slv_data;
  logic [3:0]  a_link;
  logic [1:0]  a_state;
  logic [7:0]  a_err;

  // DUT B: NSLV=3, SELW=2, TIMEOUT=4, non-posted writes
  logic [2:0]  b_mcmd;
  logic [7:0]  b_maddr, b_mdata;
  logic        b_acc_o;
  logic [1:0]  b_resp_o;
  logic [7:0]  b_sdata_o;
  logic [8:0]  b_slv_mcmd;
  logic [7:0]  b_slv_maddr, b_slv_mdata;
  logic [2:0]  b_slv_acc;
  logic [5:0]  b_slv_resp;
  logic [23:0] b_slv_data;
  logic [3:0]  b_link;
  logic [1:0]  b_state;
  logic [7:0]  b_err;

  ocp_tree_router u_a (
    .clk(clk), .rst_n(rst_n),
    .mst_MCmd(a_mcmd), .mst_MAddr(a_maddr), .mst_MData(a_mdata),
    .mst_SCmdAccept(a_acc_o), .mst_SResp(a_resp_o), .mst_SData(a_sdata_o),
    .slv_MCmd(a_slv_mcmd), .slv_MAddr(a_slv_maddr), .slv_MData(a_slv_mdata),
    .slv_SCmdAccept(a_slv_acc), .slv_SResp(a_slv_resp), .slv_SData(a_slv_data),
    .active_link(a_link), .link_state(a_state), .err_count(a_err)
  );

  ocp_tree_router #(.NSLV(3), .SELW(2), .TIMEOUT(4), .WR_RESP(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .mst_MCmd(b_mcmd), .mst_MAddr(b_maddr), .mst_MData(b_mdata),
    .mst_SCmdAccept(b_acc_o), .mst_SResp(b_resp_o), .mst_SData(b_sdata_o),
    .slv_MCmd(b_slv_mcmd), .slv_MAddr(b_slv_maddr), .slv_MData(b_slv_mdata),
    .slv_SCmdAccept(b_slv_acc), .slv_SResp(b_slv_resp), .slv_SData(b_slv_data),
    .active_link(b_link), .link_state(b_state), .err_count(b_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_mcmd = 3'b000; a_maddr = 8'h00; a_mdata = 8'h00;
    a_slv_acc = 2'b00; a_slv_resp = 4'h0; a_slv_data = 16'h0000;
    b_mcmd = 3'b000; b_maddr = 8'h00; b_mdata = 8'h00;
    b_slv_acc = 3'b000; b_slv_resp = 6'h00; b_slv_data = 24'h000000;
    tick(); tick();

    // Reset state
    chk("rst_accept",  32'(a_acc_o),     32'h1);
    chk("rst_sresp",   32'(a_resp_o),    32'h0);
    chk("rst_sdata",   32'(a_sdata_o),   32'h0);
    chk("rst_slvmcmd", 32'(a_slv_mcmd),  32'h0);
    chk("rst_maddr",   32'(a_slv_maddr), 32'h0);
    chk("rst_mdata",   32'(a_slv_mdata), 32'h0);
    chk("rst_link",    32'(a_link),      32'h0);
    chk("rst_state",   32'(a_state),     32'h0);
    chk("rst_err",     32'(a_err),       32'h0);
    rst_n = 1'b1;
    tick();

    // A: read 0x05, slave0 accepts after 2 cycles, returns DVA/0xA5
    a_mcmd = 3'b010; a_maddr = 8'h05;
    tick();
    a_mcmd = 3'b000;
    chk("rd_mcmd_c1",  32'(a_slv_mcmd), 32'h02);
    chk("rd_accept0",  32'(a_acc_o),    32'h0);
    chk("rd_state_cmd",32'(a_state),    32'h1);
    chk("rd_link",     32'(a_link),     32'h8);
    chk("rd_maddr",    32'(a_slv_maddr),32'h05);
    tick();
    chk("rd_mcmd_c2",  32'(a_slv_mcmd), 32'h02);
    tick();
    chk("rd_mcmd_c3",  32'(a_slv_mcmd), 32'h02);
    a_slv_acc = 2'b01;
    tick();
    chk("rd_mcmd_clr", 32'(a_slv_mcmd), 32'h00);
    chk("rd_state_rsp",32'(a_state),    32'h2);
    chk("rd_no_resp",  32'(a_resp_o),   32'h0);
    a_slv_acc = 2'b00; a_slv_resp = 4'b0001; a_slv_data = 16'h00A5;
    tick();
    a_slv_resp = 4'b0000; a_slv_data = 16'h0000;
    chk("rd_sresp",    32'(a_resp_o),   32'h1);
    chk("rd_sdata",    32'(a_sdata_o),  32'hA5);
    chk("rd_state_idl",32'(a_state),    32'h0);
    chk("rd_accept1",  32'(a_acc_o),    32'h1);
    tick();
    chk("rd_resp_1cyc",32'(a_resp_o),   32'h0);

    // A: posted write 0x83/0x3C to slave1
    a_mcmd = 3'b001; a_maddr = 8'h83; a_mdata = 8'h3C;
    tick();
    a_mcmd = 3'b000;
    chk("wr_mcmd",     32'(a_slv_mcmd), 32'h08);
    chk("wr_maddr",    32'(a_slv_maddr),32'h83);
    chk("wr_mdata",    32'(a_slv_mdata),32'h3C);
    a_slv_acc = 2'b10;
    tick();
    a_slv_acc = 2'b00;
    chk("wr_mcmd_clr", 32'(a_slv_mcmd), 32'h00);
    chk("wr_no_resp",  32'(a_resp_o),   32'h0);
    tick();
    chk("wr_sresp",    32'(a_resp_o),   32'h1);
    chk("wr_sdata",    32'(a_sdata_o),  32'h0);
    chk("wr_state",    32'(a_state),    32'h0);

    // A: zero-wait read from slave1 while slave0 toggles accept/ERR (ignored)
    a_mcmd = 3'b010; a_maddr = 8'h80;
    tick();
    a_mcmd = 3'b000;
    a_slv_acc = 2'b11; a_slv_resp = 4'b0011; a_slv_data = 16'h0011;
    tick();
    a_slv_acc = 2'b01; a_slv_resp = 4'b0111; a_slv_data = 16'h5A11;
    tick();
    a_slv_acc = 2'b00; a_slv_resp = 4'b0000; a_slv_data = 16'h0000;
    chk("zw_sresp",    32'(a_resp_o),   32'h1);
    chk("zw_sdata",    32'(a_sdata_o),  32'h5A);
    chk("zw_err",      32'(a_err),      32'h0);

    // B: hole read 0xC0 (index 3 with NSLV=3)
    b_mcmd = 3'b010; b_maddr = 8'hC0;
    tick();
    b_mcmd = 3'b000;
    chk("hole_mcmd",   32'(b_slv_mcmd), 32'h0);
    chk("hole_state",  32'(b_state),    32'h2);
    chk("hole_noresp", 32'(b_resp_o),   32'h0);
    tick();
    chk("hole_sresp",  32'(b_resp_o),   32'h3);
    chk("hole_sdata",  32'(b_sdata_o),  32'h0);
    chk("hole_err",    32'(b_err),      32'h1);
    chk("hole_mcmd2",  32'(b_slv_mcmd), 32'h0);

    // B: timeout, slave1 never accepts
    b_mcmd = 3'b010; b_maddr = 8'h40;
    tick();
    b_mcmd = 3'b000;
    chk("to_mcmd_c1",  32'(b_slv_mcmd), 32'h010);
    tick(); tick(); tick();
    chk("to_mcmd_c4",  32'(b_slv_mcmd), 32'h010);
    chk("to_noresp",   32'(b_resp_o),   32'h0);
    tick();
    chk("to_sresp",    32'(b_resp_o),   32'h3);
    chk("to_mcmd_clr", 32'(b_slv_mcmd), 32'h000);
    chk("to_accept",   32'(b_acc_o),    32'h1);
    chk("to_err",      32'(b_err),      32'h2);
    // late response from slave1 arriving in IDLE
    b_slv_resp = 6'b000100; b_slv_data = 24'h00EE00;
    tick();
    b_slv_resp = 6'h00; b_slv_data = 24'h000000;
    chk("late_ignored",32'(b_resp_o),   32'h0);
    chk("late_state",  32'(b_state),    32'h0);

    // B: next command accepted; non-posted write to slave2 waits for SResp
    b_mcmd = 3'b001; b_maddr = 8'h81; b_mdata = 8'h99;
    tick();
    b_mcmd = 3'b000;
    chk("nwr_mcmd",    32'(b_slv_mcmd), 32'h040);
    b_slv_acc = 3'b100;
    tick();
    b_slv_acc = 3'b000;
    tick();
    chk("nwr_wait",    32'(b_resp_o),   32'h0);
    chk("nwr_state",   32'(b_state),    32'h2);
    b_slv_resp = 6'b010000;
    tick();
    b_slv_resp = 6'h00;
    chk("nwr_sresp",   32'(b_resp_o),   32'h1);
    chk("nwr_idle",    32'(b_state),    32'h0);

    // B: reset while in RESP
    b_mcmd = 3'b010; b_maddr = 8'h00;
    tick();
    b_mcmd = 3'b000; b_slv_acc = 3'b001;
    tick();
    b_slv_acc = 3'b000;
    chk("mrst_inresp", 32'(b_state),    32'h2);
    rst_n = 1'b0; b_slv_resp = 6'b000001; b_slv_data = 24'h000077;
    tick();
    chk("mrst_state",  32'(b_state),    32'h0);
    chk("mrst_accept", 32'(b_acc_o),    32'h1);
    chk("mrst_err",    32'(b_err),      32'h0);
    chk("mrst_noresp", 32'(b_resp_o),   32'h0);
    rst_n = 1'b1; b_slv_resp = 6'h00; b_slv_data = 24'h000000;
    tick();
    chk("mrst_noresp2",32'(b_resp_o),   32'h0);

    // B: 300 hole reads saturate err_count
    for (int i = 1; i <= 300; i++) begin
      b_mcmd = 3'b010; b_maddr = 8'hC0;
      tick();
      b_mcmd = 3'b000;
      tick();
      if (i == 100) chk("sat_100", 32'(b_err), 32'd100);
    end
    chk("sat_255",     32'(b_err),      32'd255);
    chk("sat_sresp",   32'(b_resp_o),   32'h3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
